sm3_apb_sequencer: RTL

SM3_APB_SEQUENCER -- requirements
Module: sm3_apb_sequencer

---
 rtl/sm3_apb_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sm3_apb_sequencer.sv
// sm3_apb_sequencer: drives one SM3 hash block through an APB-attached SM3 core
// Sequence: load 16 message words plus the length, start, wait for the done IRQ,
// read back the 8 digest words, clear the control register, then return the
// digest on the response channel.
// Ports:
//   io_mainClk, resetCtrl_systemReset   clock, synchronous active-high reset
//   req_*                                request (message block, length, mode)
//   rsp_*                                response (digest, sticky slave-error flag)
//   m_apb_*                              APB master towards the SM3 core
//   sm3_irq                              SM3 done level, only looked at while waiting
//   busy                                 high whenever a request is in flight
// Optional: define SM3_SEQ_TIMEOUT_EN to abandon the wait for the IRQ after
// TIMEOUT_CYCLES cycles (error flagged, digest forced to zero).
module sm3_apb_sequencer #(
    parameter logic [11:0] BASE_ADDR      = 12'h200,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic         io_mainClk,
    input  logic         resetCtrl_systemReset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [511:0] req_data,
    input  logic [31:0]  req_byte_nums,
    input  logic [1:0]   req_mode,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [255:0] rsp_digest,
    output logic         rsp_error,
    output logic [11:0]  m_apb_PADDR,
    output logic         m_apb_PSEL,
    output logic         m_apb_PENABLE,
    output logic         m_apb_PWRITE,
    output logic [31:0]  m_apb_PWDATA,
    input  logic [31:0]  m_apb_PRDATA,
    input  logic         m_apb_PREADY,
    input  logic         m_apb_PSLVERROR,
    input  logic         sm3_irq,
    output logic         busy
);
    typedef enum logic [2:0] {IDLE, WR, START, WAIT_IRQ, RD, CLR, RESP} state_t;
    state_t         state_q, state_d;
    logic           phase_q, phase_d;
    logic [4:0]     idx_q, idx_d;
    logic [511:0]   data_q, data_d;
    logic [31:0]    bytes_q, bytes_d;
    logic [1:0]     mode_q, mode_d;
    logic [255:0]   digest_q, digest_d;
    logic           err_q, err_d;
    logic           apb_active, apb_done;
`ifdef SM3_SEQ_TIMEOUT_EN
    logic [31:0]    cnt_q, cnt_d;
`endif

    assign apb_active = state_q inside {WR, START, RD, CLR};
    assign apb_done   = apb_active & phase_q & m_apb_PREADY;

    always_ff @(posedge io_mainClk) begin
        if (resetCtrl_systemReset) begin
            state_q  <= IDLE;
            phase_q  <= 1'b0;
            idx_q    <= '0;
            data_q   <= '0;
            bytes_q  <= '0;
            mode_q   <= '0;
            digest_q <= '0;
            err_q    <= 1'b0;
`ifdef SM3_SEQ_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            bytes_q  <= bytes_d;
            mode_q   <= mode_d;
            digest_q <= digest_d;
            err_q    <= err_d;
`ifdef SM3_SEQ_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        bytes_d  = bytes_q;
        mode_d   = mode_q;
        digest_d = digest_q;
        err_d    = err_q;
        // SETUP always moves to ACCESS; ACCESS holds until PREADY, then the
        // next transfer (if any) starts its SETUP immediately.
        phase_d  = apb_active ? (!phase_q | !m_apb_PREADY) : 1'b0;
        if (apb_done) begin
            err_d = err_q | m_apb_PSLVERROR;
            idx_d = idx_q + 5'd1;
        end
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = WR;
                idx_d   = '0;
                data_d  = req_data;
                bytes_d = req_byte_nums;
                mode_d  = req_mode;
                err_d   = 1'b0;
            end
            WR:       if (apb_done && idx_q == 5'd16) begin state_d = START; idx_d = '0; end
            START:    if (apb_done) state_d = WAIT_IRQ;
            WAIT_IRQ: if (sm3_irq) begin state_d = RD; idx_d = '0; end
            RD: if (apb_done) begin
                digest_d[{idx_q[2:0], 5'd0} +: 32] = m_apb_PRDATA;
                if (idx_q == 5'd7) begin state_d = CLR; idx_d = '0; end
            end
            CLR:      if (apb_done) state_d = RESP;
            RESP:     if (rsp_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
`ifdef SM3_SEQ_TIMEOUT_EN
        cnt_d = (state_q == WAIT_IRQ) ? cnt_q + 32'd1 : '0;
        if (state_q == WAIT_IRQ && !sm3_irq && cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_d  = CLR;
            idx_d    = '0;
            err_d    = 1'b1;
            digest_d = '0;
        end
`endif
    end

    always_comb begin
        req_ready     = state_q == IDLE;
        busy          = state_q != IDLE;
        rsp_valid     = state_q == RESP;
        rsp_digest    = rsp_valid ? digest_q : '0;
        rsp_error     = rsp_valid & err_q;
        m_apb_PSEL    = apb_active;
        m_apb_PENABLE = apb_active & phase_q;
        m_apb_PWRITE  = apb_active & (state_q != RD);
        // idx 16 in WR lands on BASE+0x44, the length register.
        m_apb_PADDR   = state_q == WR ? BASE_ADDR + 12'h004 + {5'b0, idx_q, 2'b0} :
                        state_q == RD ? BASE_ADDR + 12'h048 + {5'b0, idx_q, 2'b0} :
                        apb_active    ? BASE_ADDR : '0;
        // Word k sits at data[511-32k -: 32], i.e. slot 15-k counted from the LSB.
        m_apb_PWDATA  = state_q == WR    ? (idx_q[4] ? bytes_q : data_q[{~idx_q[3:0], 5'd0} +: 32]) :
                        state_q == START ? {29'b0, mode_q, 1'b1} : '0;
    end
endmodule
